// File: rtl/usb_tx_encoder.sv
// USB full-speed TX encoder: SYNC, bit-stuffed NRZI data, EOP on d_plus/d_minus.
// Latency: first SYNC bit on the lines the cycle after tx_start; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: a byte is consumed (tx_data_ready pulse) only at a byte boundary; no valid there is an underrun.
// Optional build macro USB_TX_UNDERRUN_ABORT_EN: on underrun send seven held bits (stuff violation) before EOP.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_ABORT,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t        state, nxt_state;
  logic [TW-1:0] timer, nxt_timer;
  logic [2:0]    bit_idx, nxt_idx;    // bit on the line (SYNC/DATA) or period count (ABORT/EOP)
  logic [7:0]    byte_q, nxt_byte;
  logic          last_q, nxt_last;
  logic [2:0]    ones, nxt_ones;      // consecutive 1 bits sent so far
  logic          line, nxt_line;      // NRZI level: 1 = J, 0 = K
  logic          stuff, nxt_stuff;    // current period is a stuff bit
  logic          eop_pend, nxt_eop;   // stuff bit after the final data bit, EOP follows
  logic          boundary;
  logic          send_bit, send_stuff, go_eop, bit_val;

  assign boundary = (timer == TMAX);
  assign tx_busy  = (state != S_IDLE);
  assign d_plus   = (state != S_EOP_SE0) && line;
  assign d_minus  = (state != S_EOP_SE0) && !line;

  // State and datapath registers; reset parks the lines at J.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      ones     <= '0;
      line     <= 1'b1;
      stuff    <= 1'b0;
      eop_pend <= 1'b0;
    end else begin
      state    <= nxt_state;
      timer    <= nxt_timer;
      bit_idx  <= nxt_idx;
      byte_q   <= nxt_byte;
      last_q   <= nxt_last;
      ones     <= nxt_ones;
      line     <= nxt_line;
      stuff    <= nxt_stuff;
      eop_pend <= nxt_eop;
    end
  end

  // Next bit selection at each bit boundary, byte loads, stuffing, NRZI and handshake pulses.
  always_comb begin
    nxt_state     = state;
    nxt_timer     = (state == S_IDLE || boundary) ? '0 : timer + TW'(1);
    nxt_idx       = bit_idx;
    nxt_byte      = byte_q;
    nxt_last      = last_q;
    nxt_ones      = ones;
    nxt_line      = line;
    nxt_stuff     = stuff;
    nxt_eop       = eop_pend;
    tx_data_ready = 1'b0;
    tx_done       = 1'b0;
    tx_error      = 1'b0;
    send_bit      = 1'b0;
    send_stuff    = 1'b0;
    go_eop        = 1'b0;
    bit_val       = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_start) begin
          // SYNC bit 0 is a zero: the line toggles from J to K right away.
          nxt_state = S_SYNC;
          nxt_byte  = 8'h80;
          nxt_idx   = '0;
          nxt_last  = 1'b0;
          nxt_stuff = 1'b0;
          nxt_eop   = 1'b0;
          nxt_ones  = '0;
          nxt_line  = !line;
        end
      end
      S_SYNC, S_DATA: begin
        if (boundary) begin
          if (stuff) begin
            if (eop_pend) go_eop = 1'b1;
            else begin
              nxt_idx  = bit_idx + 3'd1;
              send_bit = 1'b1;
            end
          end else if (bit_idx == 3'd7) begin
            if (state == S_DATA && last_q) begin
              if (ones == 3'd6) begin
                send_stuff = 1'b1;
                nxt_eop    = 1'b1;
              end else begin
                go_eop = 1'b1;
              end
            end else if (tx_data_valid) begin
              tx_data_ready = 1'b1;
              nxt_byte      = tx_data;
              nxt_last      = tx_last;
              nxt_state     = S_DATA;
              // bit_idx stays 7 across a stuff bit so the increment wraps to bit 0.
              if (ones == 3'd6) send_stuff = 1'b1;
              else begin
                nxt_idx  = bit_idx + 3'd1;
                send_bit = 1'b1;
              end
            end else begin
              tx_error = 1'b1;
`ifdef USB_TX_UNDERRUN_ABORT_EN
              nxt_state = S_ABORT;
              nxt_idx   = '0;
              nxt_stuff = 1'b0;
`else
              go_eop = 1'b1;
`endif
            end
          end else begin
            if (ones == 3'd6) send_stuff = 1'b1;
            else begin
              nxt_idx  = bit_idx + 3'd1;
              send_bit = 1'b1;
            end
          end
        end
      end
      S_ABORT: begin
        // Line held for seven periods: an unstuffed run of ones.
        if (boundary) begin
          if (bit_idx == 3'd6) go_eop = 1'b1;
          else nxt_idx = bit_idx + 3'd1;
        end
      end
      S_EOP_SE0: begin
        if (boundary) begin
          if (bit_idx == 3'd1) begin
            nxt_state = S_EOP_J;
            nxt_idx   = '0;
          end else begin
            nxt_idx = bit_idx + 3'd1;
          end
        end
      end
      S_EOP_J: begin
        if (boundary) begin
          tx_done   = 1'b1;
          nxt_state = S_IDLE;
          nxt_ones  = '0;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    if (send_bit) begin
      bit_val   = nxt_byte[nxt_idx];
      nxt_line  = bit_val ? line : !line;
      nxt_ones  = bit_val ? ones + 3'd1 : 3'd0;
      nxt_stuff = 1'b0;
    end
    if (send_stuff) begin
      nxt_line  = !line;
      nxt_ones  = '0;
      nxt_stuff = 1'b1;
    end
    if (go_eop) begin
      nxt_state = S_EOP_SE0;
      nxt_idx   = '0;
      nxt_line  = 1'b1;
      nxt_stuff = 1'b0;
      nxt_eop   = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: reference model builds the expected per-cycle line and pulse trace
// from the packet bytes; a monitor compares every cycle of the DUT against that queue.
// Covers directed cases (0x00, 0xFF stuffing, underrun, ignored tx_start, mid-packet reset) and random packets.
module tb_usb_tx_encoder;

    localparam int C = 8;
`ifdef USB_TX_UNDERRUN_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clk;
    logic       n_rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    usb_tx_encoder #(.CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_last       (tx_last),
        .tx_data_ready (tx_data_ready),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // v = {d_plus, d_minus, tx_data_ready, tx_busy, tx_done, tx_error}
    typedef struct packed {
        logic [15:0] cyc;
        logic [5:0]  v;
    } exp_t;

    localparam logic [5:0] IDLE_V = 6'b100000;

    exp_t       exp_q[$];
    exp_t       model_q[$];
    logic [7:0] pkt[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Monitor: every cycle with an expectation queued, compare all outputs.
    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {d_plus, d_minus, tx_data_ready, tx_busy, tx_done, tx_error};
            n_checks++;
            if (a !== e.v) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got dp,dm,rdy,busy,done,err=%b expected %b", e.cyc, a, e.v);
            end
        end
    end

    // Reference model: raw bit list -> stuffing by run count -> NRZI symbols -> per-cycle trace.
    task automatic build_model(input int n_sup, input bit normal, output int total);
        int         raw[$];
        int         pos[$];
        int         em[$];
        int         syms[$];
        int         rdy_c[$];
        int         cnt;
        int         lvl;
        int         err_c;
        logic [1:0] s;
        logic       r;
        exp_t       rec;
        model_q.delete();
        for (int i = 0; i < 8; i++) raw.push_back((i == 7) ? 1 : 0);
        for (int j = 0; j < n_sup; j++)
            for (int b = 0; b < 8; b++) raw.push_back(int'(pkt[j][b]));
        cnt = 0;
        foreach (raw[i]) begin
            em.push_back(raw[i]);
            pos.push_back(em.size() - 1);
            cnt = (raw[i] != 0) ? cnt + 1 : 0;
            if (cnt == 6 && (i < raw.size() - 1 || normal)) begin
                em.push_back(0);
                cnt = 0;
            end
        end
        if (!normal && ABORT_EN) repeat (7) em.push_back(1);
        lvl = 1;
        foreach (em[i]) begin
            if (em[i] == 0) lvl = 1 - lvl;
            syms.push_back((lvl == 1) ? 2 : 1);
        end
        syms.push_back(0);
        syms.push_back(0);
        syms.push_back(2);
        total = syms.size() * C;
        for (int j = 0; j < n_sup; j++) rdy_c.push_back((pos[8*j+7] + 1) * C);
        err_c = normal ? -1 : (pos[8*n_sup+7] + 1) * C;
        for (int t = 1; t <= total; t++) begin
            s = 2'(syms[(t-1)/C]);
            r = 1'b0;
            foreach (rdy_c[k]) if (rdy_c[k] == t) r = 1'b1;
            rec.cyc = 16'(t);
            rec.v   = {s, r, 1'b1, (t == total), (t == err_c)};
            model_q.push_back(rec);
        end
        rec.cyc = 16'(total + 1);
        rec.v   = IDLE_V;
        model_q.push_back(rec);
    endtask

    // Drives one packet: pkt[0..n_sup-1] supplied; normal=0 means the source runs dry afterwards.
    task automatic send_packet(input int n_sup, input bit normal, input bit noise, input int reset_at);
        int   total;
        int   j;
        logic rdy;
        bit   seen_done;
        exp_t rec;
        build_model(n_sup, normal, total);
        j             = 0;
        seen_done     = 1'b0;
        tx_data       = (n_sup > 0) ? pkt[0] : 8'($urandom);
        tx_data_valid = (n_sup > 0);
        tx_last       = normal && (n_sup == 1);
        tx_start      = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            rdy = tx_data_ready;
            if (tx_done) seen_done = 1'b1;
            @(posedge clk);
            #1;
            if (reset_at == c + 1) begin
                exp_q.delete();
                n_rst         = 1'b0;
                tx_data_valid = 1'b0;
                tx_last       = 1'b0;
                rec.cyc       = 16'(c + 1);
                rec.v         = IDLE_V;
                exp_q.push_back(rec);
                repeat (3) @(posedge clk);
                #1;
                n_rst = 1'b1;
                return;
            end
            if (rdy) begin
                j++;
                if (j < n_sup) begin
                    tx_data = pkt[j];
                    tx_last = normal && (j == n_sup - 1);
                end else begin
                    tx_data_valid = 1'b0;
                    tx_last       = 1'b0;
                    tx_data       = 8'($urandom);
                end
            end
            tx_start = noise && (c + 1 < total - 8) && ((c % 29) == 3);
        end
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL timeout: tx_done not seen within %0d cycles of tx_start", total + 1);
        end
        tx_start      = 1'b0;
        tx_data_valid = 1'b0;
        tx_last       = 1'b0;
    endtask

    initial begin
        exp_t rec;
        int   n;
        bit   normal;
        int   n_sup;
        n_rst         = 1'b0;
        tx_start      = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        tx_last       = 1'b0;
        rec.cyc = 16'd0;
        rec.v   = IDLE_V;
        exp_q.push_back(rec);
        @(negedge clk);
        n_checks++;
        if ({d_plus, d_minus, tx_data_ready, tx_busy, tx_done, tx_error} !== IDLE_V) begin
            n_fail++;
            $display("FAIL reset state: got dp,dm,rdy,busy,done,err=%b expected %b",
                     {d_plus, d_minus, tx_data_ready, tx_busy, tx_done, tx_error}, IDLE_V);
        end
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        pkt = '{8'h00};               send_packet(1, 1'b1, 1'b0, 0);
        pkt = '{8'hFF};               send_packet(1, 1'b1, 1'b0, 0);
        pkt = '{8'hFF, 8'hFF};        send_packet(2, 1'b1, 1'b0, 0);
        pkt = '{8'hFF, 8'h5A};        send_packet(1, 1'b0, 1'b0, 0);
        pkt = '{8'h00};               send_packet(1, 1'b1, 1'b1, 0);
        pkt = '{8'hA5, 8'h3C, 8'h0F}; send_packet(3, 1'b1, 1'b0, 100);
        pkt = '{8'h7E, 8'hFF};        send_packet(2, 1'b1, 1'b0, 0);
        pkt = '{8'h12};               send_packet(0, 1'b0, 1'b0, 0);
        pkt = '{8'h3F, 8'hFC};        send_packet(2, 1'b1, 1'b0, 0);

        for (int k = 0; k < 16; k++) begin
            n = $urandom_range(1, 4);
            pkt.delete();
            for (int b = 0; b < n; b++)
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            normal = ($urandom_range(0, 3) != 0);
            n_sup  = normal ? n : $urandom_range(0, n - 1);
            send_packet(n_sup, normal, 1'($urandom_range(0, 1)), 0);
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
